data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter NBITS, default 32: data and address width.
REQ-002 Parameter DEPTH, default 256: number of NBITS-wide words; a power of two, at least 4.
REQ-003 Parameter WAIT, default 1: extra busy cycles per access; range 0-15.
REQ-004 clk  in  1: single clock; all state updates on the rising edge.
REQ-005 rst  in  1: reset, synchronous and active-high.
REQ-006 req_valid  in  1: initiator presents a request.
REQ-007 req_ready  out  1: responder can accept a request.
REQ-008 req_we  in  1: 1 = store, 0 = load.
REQ-009 req_size  in  2: access size; 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-010 req_unsigned  in  1: on loads, 1 = zero-extend, 0 = sign-extend.
REQ-011 req_addr  in  NBITS: byte address.
REQ-012 req_wdata  in  NBITS: store data, right-aligned.
REQ-013 rsp_valid  out  1: one-cycle response strobe.
REQ-014 rsp_rdata  out  NBITS: load result.
REQ-015 rsp_err  out  1: request rejected.
REQ-016 test_valu  out  16: bits [15:0] of word 0, combinational from the array.

Function
REQ-017 FSM states are IDLE, BUSY and RESP; req_ready = 1 only in IDLE.
REQ-018 Handshake: a request is accepted on the edge where req_valid = 1 and req_ready = 1; accepting latches req_we, req_size, req_unsigned, req_addr and req_wdata; later input changes have no effect.
REQ-019 IDLE -> BUSY on acceptance, with the wait counter loaded to WAIT.
REQ-020 BUSY, counter != 0 -> stay in BUSY and decrement the counter.
REQ-021 BUSY, counter == 0 -> RESP; on that edge the access is performed (array write, read capture, error evaluation).
REQ-022 RESP -> IDLE unconditionally; rsp_valid = 1 for exactly that one cycle; no backpressure.
REQ-023 Latency: rsp_valid rises on the (WAIT+1)th edge after the accepting edge; the earliest next acceptance is edge WAIT+3.
REQ-024 Word index = addr[log2(DEPTH)+1:2]; higher address bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
REQ-025 Byte lanes are little-endian: addr[1:0] = 0 selects bits [7:0] … addr[1:0] = 3 selects bits [31:24]; a half at addr[1] = 1 occupies bits [31:16].
REQ-026 A misaligned or illegal request is rejected (rsp_err = 1, no array write, rsp_rdata = 0). This covers:
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - req_size = 11.
REQ-027 A store writes only the addressed lanes, taking wdata[7:0] for a byte, [15:0] for a half, [31:0] for a word; the other lanes are unchanged.
REQ-028 A load extracts the addressed lanes, then sign- or zero-extends them per the latched req_unsigned; word loads ignore req_unsigned.
REQ-029 A store response has rsp_rdata = 0 and rsp_err = 0.
REQ-030 rsp_rdata and rsp_err are held until the next response and are meaningful only while rsp_valid = 1.
REQ-031 test_valu reflects a store to word 0 in the cycle after the write edge.

Reset
REQ-032 When rst = 1 at an edge:
  - state goes to IDLE and the counter clears;
  - req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0;
  - all array words clear to 0, so test_valu = 0.
REQ-033 Reset during BUSY aborts the request: no array write and no response.
REQ-034 A request presented while rst = 1 is not accepted.

Verification
REQ-035 WAIT = 1. Store word 0xDEADBEEF at 0x4 accepted at edge 0 -> rsp_valid high after edge 2 only, rsp_err = 0. Then load word at 0x4 -> rsp_rdata = 0xDEADBEEF.
REQ-036 Word at 0x8 = 0xCAFEBABE.
  - Load byte signed at 0xB -> 0xFFFFFFCA.
  - Load byte unsigned at 0xB -> 0x000000CA.
  - Load half signed at 0x8 -> 0xFFFFBABE.
REQ-037 Word at 0x8 = 0xCAFEBABE; store byte 0x11 at 0x9 -> word at 0x8 reads 0xCAFE11BE. Store half 0x2233 at 0xA -> 0x223311BE.
REQ-038 Rejections, each -> rsp_err = 1, rsp_rdata = 0, target word unchanged:
  - store word at 0x6;
  - load half at 0x3;
  - req_size = 11.
REQ-039 DEPTH = 256. Store word 0x12345678 at 0x400 -> load word at 0x0 returns 0x12345678 and test_valu = 0x5678.
REQ-040 WAIT = 3. Store to 0x10, rst pulsed during BUSY -> no rsp_valid, word at 0x10 = 0, req_ready = 1 the cycle after reset.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-port byte-addressable data memory that answers one
// load/store request at a time after a fixed number of busy cycles.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   req_valid/ready   - request handshake (ready only while idle)
//   req_we            - 1 = store, 0 = load
//   req_size          - 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned      - load zero-extend (1) or sign-extend (0)
//   req_addr          - byte address (wraps modulo 4*DEPTH)
//   req_wdata         - right-aligned store data
//   rsp_valid         - one-cycle response strobe
//   rsp_rdata/rsp_err - load result / rejection flag, held until next response
//   test_valu         - bits [15:0] of word 0, combinational
module data_mem_responder #(
  parameter int unsigned NBITS = 32,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WAIT  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [NBITS-1:0] req_addr,
  input  logic [NBITS-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [NBITS-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic [15:0]      test_valu
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [NBITS-1:0] addr_q, addr_d;
  logic [NBITS-1:0] wdata_q, wdata_d;
  logic             ready_q, ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [NBITS-1:0] rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;
  logic             mem_we;

  logic [NBITS-1:0] mem_q [DEPTH];

  // Access datapath on the latched request
  logic [AW-1:0]    acc_idx;
  logic [4:0]       shamt;
  logic [NBITS-1:0] rd_word, shifted, lane_mask, wd_shift, wr_word, load_val;
  logic             acc_err;

  always_comb begin
    acc_idx  = addr_q[AW+1:2];
    shamt    = {addr_q[1:0], 3'b000};
    rd_word  = mem_q[acc_idx];
    shifted  = rd_word >> shamt;
    wd_shift = wdata_q << shamt;
    acc_err  = (size_q == 2'b11) ||
               (size_q == 2'b01 && addr_q[0]) ||
               (size_q == 2'b10 && addr_q[1:0] != 2'b00);
    lane_mask = '1;
    load_val  = shifted;
    case (size_q)
      2'b00: begin
        lane_mask = NBITS'(8'hFF) << shamt;
        load_val  = uns_q ? NBITS'(shifted[7:0])
                          : {{(NBITS-8){shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        lane_mask = NBITS'(16'hFFFF) << shamt;
        load_val  = uns_q ? NBITS'(shifted[15:0])
                          : {{(NBITS-16){shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
    wr_word = (rd_word & ~lane_mask) | (wd_shift & lane_mask);
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CW'(WAIT);
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = acc_err;
          rsp_rdata_d = (we_q || acc_err) ? '0 : load_val;
          mem_we      = we_q && !acc_err;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  // State, request latch and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Memory array; reset clears every word
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[acc_idx] <= wr_word;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign test_valu = mem_q[0][15:0];

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: instance A (WAIT=1) covers the access functions, instance B
// (WAIT=3) covers reset during a busy access.
module tb_data_mem_responder;

  logic        clk;
  logic        a_rst, a_valid, a_ready, a_we, a_uns, a_rv, a_err;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [15:0] a_valu;
  logic        b_rst, b_valid, b_ready, b_we, b_uns, b_rv, b_err;
  logic [1:0]  b_size;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [15:0] b_valu;

  int total = 0;
  int bad   = 0;

  data_mem_responder #(.NBITS(32), .DEPTH(256), .WAIT(1)) dut_a (
    .clk(clk), .rst(a_rst), .req_valid(a_valid), .req_ready(a_ready),
    .req_we(a_we), .req_size(a_size), .req_unsigned(a_uns), .req_addr(a_addr),
    .req_wdata(a_wdata), .rsp_valid(a_rv), .rsp_rdata(a_rdata),
    .rsp_err(a_err), .test_valu(a_valu)
  );

  data_mem_responder #(.NBITS(32), .DEPTH(256), .WAIT(3)) dut_b (
    .clk(clk), .rst(b_rst), .req_valid(b_valid), .req_ready(b_ready),
    .req_we(b_we), .req_size(b_size), .req_unsigned(b_uns), .req_addr(b_addr),
    .req_wdata(b_wdata), .rsp_valid(b_rv), .rsp_rdata(b_rdata),
    .rsp_err(b_err), .test_valu(b_valu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request, scramble the inputs right after acceptance, then wait
  // for the response. lat = number of edges after the accepting edge.
  task automatic access(input bit sel, input bit we, input logic [1:0] sz,
                        input bit uns, input logic [31:0] ad, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    if (!sel) begin
      a_valid = 1'b1; a_we = we; a_size = sz; a_uns = uns; a_addr = ad; a_wdata = wd;
    end else begin
      b_valid = 1'b1; b_we = we; b_size = sz; b_uns = uns; b_addr = ad; b_wdata = wd;
    end
    @(posedge clk); #1;
    if (!sel) begin
      a_valid = 1'b0; a_we = ~we; a_size = ~sz; a_uns = ~uns; a_addr = ~ad; a_wdata = ~wd;
    end else begin
      b_valid = 1'b0; b_we = ~we; b_size = ~sz; b_uns = ~uns; b_addr = ~ad; b_wdata = ~wd;
    end
    lat = -1; rd = '0; er = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if ((sel ? b_rv : a_rv) === 1'b1) begin
        lat = i;
        rd  = sel ? b_rdata : a_rdata;
        er  = sel ? b_err : a_err;
        break;
      end
    end
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL timeout addr=%h: no rsp_valid within 24 cycles", ad);
    end
  endtask

  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1;
    a_valid = 1'b1; a_we = 1'b1; a_size = 2'b10; a_uns = 1'b0;
    a_addr = 32'h0; a_wdata = 32'hFFFF_FFFF;
    b_valid = 1'b0; b_we = 1'b0; b_size = 2'b00; b_uns = 1'b0;
    b_addr = 32'h0; b_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (a_ready !== 1'b1 || a_rv !== 1'b0 || a_rdata !== 32'h0 || a_err !== 1'b0 || a_valu !== 16'h0) begin
      bad++;
      $display("FAIL reset_state: ready=%b rv=%b rdata=%h err=%b valu=%h, required 1 0 0 0 0",
               a_ready, a_rv, a_rdata, a_err, a_valu);
    end
    a_rst = 1'b0; b_rst = 1'b0; a_valid = 1'b0;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (a_rv === 1'b1 || a_ready !== 1'b1) seen = 1'b1;
      end
      total++;
      if (seen || a_valu !== 16'h0) begin
        bad++;
        $display("FAIL req_in_reset: accepted=%b valu=%h, required 0 0000", seen, a_valu);
      end
    end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    total++;
    if (a_ready !== 1'b1) begin
      bad++; $display("FAIL ready_idle: got %b required 1", a_ready);
    end
    access(0, 1, 2'b10, 0, 32'h4, 32'hDEAD_BEEF, rd, er, lat);
    total++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h0) begin
      bad++;
      $display("FAIL store_word: lat=%0d err=%b rdata=%h, required 2 0 00000000", lat, er, rd);
    end
    access(0, 0, 2'b10, 1, 32'h4, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
      bad++;
      $display("FAIL load_word: rdata=%h err=%b, required deadbeef 0", rd, er);
    end
  endtask

  task automatic test_extend();
    logic [31:0] rd; logic er; int lat;
    access(0, 1, 2'b10, 0, 32'h8, 32'hCAFE_BABE, rd, er, lat);
    access(0, 0, 2'b00, 0, 32'hB, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'hFFFF_FFCA) begin bad++; $display("FAIL lb_signed: got %h required ffffffca", rd); end
    access(0, 0, 2'b00, 1, 32'hB, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h0000_00CA) begin bad++; $display("FAIL lb_unsigned: got %h required 000000ca", rd); end
    access(0, 0, 2'b01, 0, 32'h8, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'hFFFF_BABE) begin bad++; $display("FAIL lh_signed: got %h required ffffbabe", rd); end
    access(0, 0, 2'b01, 1, 32'hA, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h0000_CAFE) begin bad++; $display("FAIL lh_unsigned_hi: got %h required 0000cafe", rd); end
    access(0, 0, 2'b00, 0, 32'h9, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'hFFFF_FFBA) begin bad++; $display("FAIL lb_signed_lane1: got %h required ffffffba", rd); end
  endtask

  task automatic test_partial_store();
    logic [31:0] rd; logic er; int lat;
    access(0, 1, 2'b00, 0, 32'h9, 32'hAAAA_AA11, rd, er, lat);
    access(0, 0, 2'b10, 0, 32'h8, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'hCAFE_11BE) begin bad++; $display("FAIL sb_lane1: got %h required cafe11be", rd); end
    access(0, 1, 2'b01, 0, 32'hA, 32'h5555_2233, rd, er, lat);
    access(0, 0, 2'b10, 0, 32'h8, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h2233_11BE) begin bad++; $display("FAIL sh_upper: got %h required 223311be", rd); end
  endtask

  task automatic test_reject();
    logic [31:0] rd; logic er; int lat;
    access(0, 1, 2'b10, 0, 32'h6, 32'h9999_9999, rd, er, lat);
    total++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("FAIL rej_sw_misaligned: err=%b rdata=%h, required 1 00000000", er, rd);
    end
    access(0, 0, 2'b10, 0, 32'h4, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
      bad++; $display("FAIL rej_sw_unchanged: rdata=%h err=%b, required deadbeef 0", rd, er);
    end
    access(0, 0, 2'b01, 0, 32'h3, 32'h0, rd, er, lat);
    total++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("FAIL rej_lh_misaligned: err=%b rdata=%h, required 1 00000000", er, rd);
    end
    access(0, 1, 2'b11, 0, 32'h8, 32'h7777_7777, rd, er, lat);
    total++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("FAIL rej_size11: err=%b rdata=%h, required 1 00000000", er, rd);
    end
    access(0, 0, 2'b10, 0, 32'h8, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h2233_11BE || er !== 1'b0) begin
      bad++; $display("FAIL rej_size11_unchanged: rdata=%h err=%b, required 223311be 0", rd, er);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic er; int lat;
    access(0, 1, 2'b10, 0, 32'h400, 32'h1234_5678, rd, er, lat);
    total++;
    if (a_valu !== 16'h5678) begin bad++; $display("FAIL test_valu: got %h required 5678", a_valu); end
    access(0, 0, 2'b10, 0, 32'h0, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h1234_5678) begin bad++; $display("FAIL wrap_load: got %h required 12345678", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat;
    access(0, 0, 2'b10, 0, 32'h4, 32'h0, rd, er, lat);
    total++;
    if (a_ready !== 1'b0) begin bad++; $display("FAIL ready_in_resp: got %b required 0", a_ready); end
    @(negedge clk);
    total++;
    if (a_ready !== 1'b1 || a_rv !== 1'b0 || a_rdata !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL after_resp: ready=%b rv=%b rdata=%h, required 1 0 deadbeef", a_ready, a_rv, a_rdata);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er; int lat;
    bit seen;
    @(negedge clk);
    b_valid = 1'b1; b_we = 1'b1; b_size = 2'b10; b_uns = 1'b0;
    b_addr = 32'h10; b_wdata = 32'hAAAA_5555;
    @(posedge clk); #1;
    b_valid = 1'b0;
    @(negedge clk);
    b_rst = 1'b1;
    @(negedge clk);
    b_rst = 1'b0;
    total++;
    if (b_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset: got %b required 1", b_ready); end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (b_rv === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL abort_no_rsp: rsp_valid seen=%b required 0", seen); end
    access(1, 0, 2'b10, 0, 32'h10, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h0 || lat !== 4) begin
      bad++; $display("FAIL abort_no_write: rdata=%h lat=%0d, required 00000000 4", rd, lat);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_extend();
    test_partial_store();
    test_reject();
    test_wrap();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
